bayer_demosaic_3x3: RTL



---
 rtl/demosaic_pkg.sv | 53 +++++
 rtl/bayer_linebuf.sv | 44 ++++
 rtl/bayer_demosaic_3x3.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/demosaic_pkg.sv
// Shared phase codes, sum width and averaging helpers
// for the RGGB bilinear demosaic stage.
package demosaic_pkg;

    localparam logic [1:0] PH_R  = 2'd0;
    localparam logic [1:0] PH_GR = 2'd1;
    localparam logic [1:0] PH_GB = 2'd2;
    localparam logic [1:0] PH_B  = 2'd3;

    localparam int SUM_W = 10;

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } state_t;

    // Arguments are the parity of the window centre (1 = odd).
    function automatic logic [1:0] phase_of(
        input logic r_odd,
        input logic c_odd
    );
        logic [1:0] ph;
        ph = PH_R;
        unique case ({r_odd, c_odd})
            2'b00: ph = PH_R;
            2'b01: ph = PH_GR;
            2'b10: ph = PH_GB;
            2'b11: ph = PH_B;
        endcase
        return ph;
    endfunction

    function automatic logic [7:0] avg2(
        input logic [7:0] a,
        input logic [7:0] b
    );
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(b);
        return 8'(s >> 1);
    endfunction

    function automatic logic [7:0] avg4(
        input logic [7:0] a,
        input logic [7:0] b,
        input logic [7:0] c,
        input logic [7:0] d
    );
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(b) + SUM_W'(c) + SUM_W'(d);
        return 8'(s >> 2);
    endfunction

endpackage

// File: rtl/bayer_linebuf.sv
// Two chained IMG_W-deep line delays; taps give the current,
// previous and second-previous line at the same column.
module bayer_linebuf
    import demosaic_pkg::*;
#(
    parameter int IMG_W = 640
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic [7:0] i_pix,
    output logic [7:0] o_tap0,
    output logic [7:0] o_tap1,
    output logic [7:0] o_tap2
);

    localparam int PW = $clog2(IMG_W);
    localparam logic [PW-1:0] PTR_LAST = PW'(IMG_W - 1);

    logic [7:0]    r_line1 [IMG_W];
    logic [7:0]    r_line2 [IMG_W];
    logic [PW-1:0] r_ptr;

    assign o_tap0 = i_pix;
    assign o_tap1 = r_line1[r_ptr];
    assign o_tap2 = r_line2[r_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_en) begin
            r_ptr <= (r_ptr == PTR_LAST) ? '0 : r_ptr + PW'(1);
        end
    end

    // Read-before-write at the same slot yields an exact IMG_W delay.
    always_ff @(posedge clk) begin
        if (i_en) begin
            r_line1[r_ptr] <= i_pix;
            r_line2[r_ptr] <= o_tap1;
        end
    end

endmodule

// File: rtl/bayer_demosaic_3x3.sv
// Bilinear RGGB demosaic: 3x3 window over two line buffers,
// one registered RGB pixel per interior input pixel.
module bayer_demosaic_3x3
    import demosaic_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_valid,
    input  logic       pix_sof,
    input  logic [7:0] pix_data,
    output logic       rgb_valid,
    output logic       rgb_sof,
    output logic [7:0] rgb_r,
    output logic [7:0] rgb_g,
    output logic [7:0] rgb_b
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    state_t        r_state;
    state_t        w_state_nx;
    logic [CW-1:0] r_col;
    logic [CW-1:0] w_col;
    logic [CW-1:0] w_col_nx;
    logic [RW-1:0] r_row;
    logic [RW-1:0] w_row;
    logic [RW-1:0] w_row_nx;
    logic          w_acc;
    logic          w_last;
    logic          w_out_en;
    logic [7:0]    w_tap0;
    logic [7:0]    w_tap1;
    logic [7:0]    w_tap2;
    logic [7:0]    r_win [3][3];
    logic [7:0]    w_win [3][3];
    logic [1:0]    w_phase;
    logic [7:0]    w_cross;
    logic [7:0]    w_diag;
    logic [7:0]    w_we;
    logic [7:0]    w_ns;
    logic [7:0]    w_r;
    logic [7:0]    w_g;
    logic [7:0]    w_b;

    bayer_linebuf #(
        .IMG_W(IMG_W)
    ) u_linebuf (
        .clk   (clk),
        .rst   (rst),
        .i_en  (pix_valid),
        .i_pix (pix_data),
        .o_tap0(w_tap0),
        .o_tap1(w_tap1),
        .o_tap2(w_tap2)
    );

    // Window rows: 0 north, 1 centre, 2 south; cols: 0 west, 2 east.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_win[i][0] = r_win[i][1];
            w_win[i][1] = r_win[i][2];
        end
        w_win[0][2] = w_tap2;
        w_win[1][2] = w_tap1;
        w_win[2][2] = w_tap0;
    end

    always_ff @(posedge clk) begin
        if (pix_valid) begin
            r_win <= w_win;
        end
    end

    assign w_acc    = pix_valid && (pix_sof || r_state == ST_ACTIVE);
    assign w_col    = pix_sof ? '0 : r_col;
    assign w_row    = pix_sof ? '0 : r_row;
    assign w_last   = (w_col == COL_LAST) && (w_row == ROW_LAST);
    assign w_out_en = w_acc && (w_row >= RW'(2)) && (w_col >= CW'(2));

    always_comb begin
        w_state_nx = r_state;
        w_col_nx   = r_col;
        w_row_nx   = r_row;
        if (w_acc) begin
            if (w_last) begin
                w_state_nx = ST_IDLE;
                w_col_nx   = '0;
                w_row_nx   = '0;
            end else begin
                w_state_nx = ST_ACTIVE;
                if (w_col == COL_LAST) begin
                    w_col_nx = '0;
                    w_row_nx = w_row + RW'(1);
                end else begin
                    w_col_nx = w_col + CW'(1);
                    w_row_nx = w_row;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_col   <= '0;
            r_row   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_col   <= w_col_nx;
            r_row   <= w_row_nx;
        end
    end

    // Centre sits at (row-1, col-1), so its parity is the inverse LSB.
    always_comb begin
        w_phase = phase_of(~w_row[0], ~w_col[0]);
        w_cross = avg4(w_win[0][1], w_win[2][1], w_win[1][0], w_win[1][2]);
        w_diag  = avg4(w_win[0][0], w_win[0][2], w_win[2][0], w_win[2][2]);
        w_we    = avg2(w_win[1][0], w_win[1][2]);
        w_ns    = avg2(w_win[0][1], w_win[2][1]);
        w_r     = w_win[1][1];
        w_g     = w_win[1][1];
        w_b     = w_win[1][1];
        unique case (w_phase)
            PH_R:  begin w_g = w_cross; w_b = w_diag; end
            PH_B:  begin w_r = w_diag;  w_g = w_cross; end
            PH_GR: begin w_r = w_we;    w_b = w_ns; end
            PH_GB: begin w_r = w_ns;    w_b = w_we; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_valid <= 1'b0;
            rgb_sof   <= 1'b0;
            rgb_r     <= '0;
            rgb_g     <= '0;
            rgb_b     <= '0;
        end else begin
            rgb_valid <= w_out_en;
            rgb_sof   <= w_out_en && (w_row == RW'(2)) && (w_col == CW'(2));
            if (w_out_en) begin
                rgb_r <= w_r;
                rgb_g <= w_g;
                rgb_b <= w_b;
            end
        end
    end

endmodule
